// File: rtl/bus_responder_pkg.sv
// rtl/bus_responder_pkg.sv - shared FSM state type and turnaround constant for bus_responder
package bus_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WACK,
    TURN,
    DRIVE,
    RELEASE
  } state_t;

  // Idle bus cycles between the read request and the responder driving data.
  localparam int TURN_CYCLES = 1;

endpackage

// File: rtl/bus_responder_if.sv
// rtl/bus_responder_if.sv - initiator/responder handshake and shared tri-state word bus (parity: BUS_RESPONDER_PARITY_EN)
interface bus_responder_if #(
  parameter int WIDTH  = 10,
  parameter int ADDR_W = 2
) ();

  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  wire  [WIDTH-1:0]  io_bus;
  logic              o_ack;
  logic              o_busy;
`ifdef BUS_RESPONDER_PARITY_EN
  logic              i_par;
  logic              o_par;
  logic              o_perr;
`endif

  modport slave (
    input  i_req,
    input  i_we,
    input  i_addr,
    inout  io_bus,
`ifdef BUS_RESPONDER_PARITY_EN
    input  i_par,
    output o_par,
    output o_perr,
`endif
    output o_ack,
    output o_busy
  );

  modport master (
    output i_req,
    output i_we,
    output i_addr,
    inout  io_bus,
`ifdef BUS_RESPONDER_PARITY_EN
    output i_par,
    input  o_par,
    input  o_perr,
`endif
    input  o_ack,
    input  o_busy
  );

endinterface

// File: rtl/bus_responder_regfile.sv
// rtl/bus_responder_regfile.sv - DEPTH x WIDTH register file, sync write, comb read (parity: BUS_RESPONDER_PARITY_EN)
module bus_responder_regfile #(
  parameter  int WIDTH  = 10,
  parameter  int DEPTH  = 4,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
`ifdef BUS_RESPONDER_PARITY_EN
  input  logic              wr_par,
  output logic              rd_par,
`endif
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
`ifdef BUS_RESPONDER_PARITY_EN
  logic             par_mem [DEPTH];
`endif
  logic             wr_ok;
  logic             rd_ok;

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_pow2
      assign wr_ok = 1'b1;
      assign rd_ok = 1'b1;
    end else begin : g_npow2
      assign wr_ok = (32'(wr_addr) < DEPTH);
      assign rd_ok = (32'(rd_addr) < DEPTH);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
`ifdef BUS_RESPONDER_PARITY_EN
        par_mem[i] <= 1'b0;
`endif
      end
    end else if (wr_en && wr_ok) begin
      mem[wr_addr] <= wr_data;
`ifdef BUS_RESPONDER_PARITY_EN
      par_mem[wr_addr] <= wr_par;
`endif
    end
  end

  assign rd_data = rd_ok ? mem[rd_addr] : '0;
`ifdef BUS_RESPONDER_PARITY_EN
  assign rd_par  = rd_ok ? par_mem[rd_addr] : 1'b0;
`endif

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - tri-state bus responder: FSM, address latch and bus driver (parity: BUS_RESPONDER_PARITY_EN)
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  bus_responder_if.slave  bus
);

  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  logic [1:0]        turn_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              drive_en;
  logic [WIDTH-1:0]  drive_data;
  logic              wr_en;
  logic [WIDTH-1:0]  rd_data;
`ifdef BUS_RESPONDER_PARITY_EN
  logic              rd_par;
`endif

  assign wr_en = (state == IDLE) && bus.i_req && bus.i_we;

  bus_responder_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .wr_en   (wr_en),
    .wr_addr (bus.i_addr),
    .wr_data (bus.io_bus),
`ifdef BUS_RESPONDER_PARITY_EN
    .wr_par  (^bus.io_bus),
    .rd_par  (rd_par),
`endif
    .rd_addr (addr_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      turn_cnt   <= '0;
      addr_q     <= '0;
      drive_en   <= 1'b0;
      drive_data <= '0;
      bus.o_ack  <= 1'b0;
      bus.o_busy <= 1'b0;
`ifdef BUS_RESPONDER_PARITY_EN
      bus.o_par  <= 1'b0;
      bus.o_perr <= 1'b0;
`endif
    end else begin
      bus.o_ack <= 1'b0;
      drive_en  <= 1'b0;
`ifdef BUS_RESPONDER_PARITY_EN
      bus.o_par  <= 1'b0;
      bus.o_perr <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.i_req) begin
            bus.o_busy <= 1'b1;
            if (bus.i_we) begin
              state     <= WACK;
              bus.o_ack <= 1'b1;
`ifdef BUS_RESPONDER_PARITY_EN
              bus.o_perr <= (bus.i_par != ^bus.io_bus);
`endif
            end else begin
              state    <= TURN;
              addr_q   <= bus.i_addr;
              turn_cnt <= '0;
            end
          end
        end
        WACK: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
        TURN: begin
          if (turn_cnt == 2'(TURN_CYCLES - 1)) begin
            // Capture read data here so the bus value is a clean register in DRIVE.
            state      <= DRIVE;
            drive_en   <= 1'b1;
            drive_data <= rd_data;
            bus.o_ack  <= 1'b1;
`ifdef BUS_RESPONDER_PARITY_EN
            bus.o_par  <= rd_par;
`endif
          end else begin
            turn_cnt <= turn_cnt + 2'd1;
          end
        end
        DRIVE: begin
          state <= RELEASE;
        end
        RELEASE: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          bus.o_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.io_bus = drive_en ? drive_data : {WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - directed self-checking bench for bus_responder (parity steps: BUS_RESPONDER_PARITY_EN)
module tb_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       tb_oe;
  logic [9:0] tb_dat;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         ack_cnt;
  int         busy_cnt;

  bus_responder_if #(.WIDTH(10), .ADDR_W(2)) bus_if ();

  // The bench pulls the bus to a known value whenever the responder must be off it.
  assign bus_if.io_bus = tb_oe ? tb_dat : 10'bz;

  bus_responder #(.WIDTH(10), .DEPTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [9:0] d);
    bus_if.i_req  = 1'b1;
    bus_if.i_we   = 1'b1;
    bus_if.i_addr = a;
    tb_dat        = d;
    check("wr_req_ack", 16'(bus_if.o_ack), 16'h0);
    tick();
    bus_if.i_req = 1'b0;
    tb_dat       = 10'h000;
    check("wr_wack_ack", 16'(bus_if.o_ack), 16'h1);
    check("wr_wack_busy", 16'(bus_if.o_busy), 16'h1);
    tick();
    check("wr_idle_ack", 16'(bus_if.o_ack), 16'h0);
    check("wr_idle_busy", 16'(bus_if.o_busy), 16'h0);
  endtask

  task automatic do_read(input logic [1:0] a, input logic [9:0] exp, input string tag);
    bus_if.i_req  = 1'b1;
    bus_if.i_we   = 1'b0;
    bus_if.i_addr = a;
    tick();
    bus_if.i_req  = 1'b0;
    bus_if.i_addr = ~a;
    check({tag, "_turn_busy"}, 16'(bus_if.o_busy), 16'h1);
    check({tag, "_turn_ack"}, 16'(bus_if.o_ack), 16'h0);
    check({tag, "_turn_bus"}, 16'(bus_if.io_bus), 16'h000);
    tb_oe = 1'b0;
    tick();
    check({tag, "_drive_ack"}, 16'(bus_if.o_ack), 16'h1);
    check({tag, "_drive_bus"}, 16'(bus_if.io_bus), 16'(exp));
    check({tag, "_drive_busy"}, 16'(bus_if.o_busy), 16'h1);
    tick();
    tb_oe = 1'b1;
    #1;
    check({tag, "_rel_bus"}, 16'(bus_if.io_bus), 16'h000);
    check({tag, "_rel_ack"}, 16'(bus_if.o_ack), 16'h0);
    check({tag, "_rel_busy"}, 16'(bus_if.o_busy), 16'h1);
    tick();
    check({tag, "_idle_busy"}, 16'(bus_if.o_busy), 16'h0);
    check({tag, "_idle_ack"}, 16'(bus_if.o_ack), 16'h0);
  endtask

  initial begin
    rst           = 1'b1;
    tb_oe         = 1'b1;
    tb_dat        = 10'h000;
    bus_if.i_req  = 1'b0;
    bus_if.i_we   = 1'b0;
    bus_if.i_addr = 2'd0;
`ifdef BUS_RESPONDER_PARITY_EN
    bus_if.i_par  = 1'b0;
`endif

    #2 rst = 1'b0;
    #1;
    check("rst_ack", 16'(bus_if.o_ack), 16'h0);
    check("rst_busy", 16'(bus_if.o_busy), 16'h0);
    check("rst_bus", 16'(bus_if.io_bus), 16'h000);
    tick();
    tick();
    rst = 1'b1;
    check("post_rst_ack", 16'(bus_if.o_ack), 16'h0);
    check("post_rst_busy", 16'(bus_if.o_busy), 16'h0);
    tick();

    do_read(2'd2, 10'h000, "rd2_reset");

    do_write(2'd1, 10'h2A5);
    do_read(2'd1, 10'h2A5, "rd1");

    do_write(2'd3, 10'h3FF);
    do_read(2'd3, 10'h3FF, "rd3_b2b");

    // Request held high through a whole read; strobes outside IDLE must be ignored.
    tb_oe         = 1'b0;
    ack_cnt       = 0;
    busy_cnt      = 0;
    bus_if.i_req  = 1'b1;
    bus_if.i_we   = 1'b0;
    bus_if.i_addr = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      ack_cnt  += int'(bus_if.o_ack);
      busy_cnt += int'(bus_if.o_busy);
    end
    bus_if.i_req = 1'b0;
    tick();
    ack_cnt  += int'(bus_if.o_ack);
    busy_cnt += int'(bus_if.o_busy);
    tb_oe = 1'b1;
    check("held_req_acks", 16'(ack_cnt), 16'd1);
    check("held_req_busy_cycles", 16'(busy_cnt), 16'd3);

    // Reset while in TURN: abandon the read, no ack afterwards, storage cleared.
    bus_if.i_req  = 1'b1;
    bus_if.i_we   = 1'b0;
    bus_if.i_addr = 2'd3;
    tick();
    bus_if.i_req = 1'b0;
    check("turn_busy_before_rst", 16'(bus_if.o_busy), 16'h1);
    rst = 1'b0;
    #1;
    check("mid_rst_bus", 16'(bus_if.io_bus), 16'h000);
    check("mid_rst_ack", 16'(bus_if.o_ack), 16'h0);
    check("mid_rst_busy", 16'(bus_if.o_busy), 16'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("after_rst_ack", 16'(bus_if.o_ack), 16'h0);
      check("after_rst_busy", 16'(bus_if.o_busy), 16'h0);
    end
    do_read(2'd0, 10'h000, "clr0");
    do_read(2'd1, 10'h000, "clr1");
    do_read(2'd2, 10'h000, "clr2");
    do_read(2'd3, 10'h000, "clr3");

`ifdef BUS_RESPONDER_PARITY_EN
    // 10'h001 has odd parity, so i_par=0 is wrong and must flag an error.
    bus_if.i_par  = 1'b0;
    bus_if.i_req  = 1'b1;
    bus_if.i_we   = 1'b1;
    bus_if.i_addr = 2'd0;
    tb_dat        = 10'h001;
    tick();
    bus_if.i_req = 1'b0;
    tb_dat       = 10'h000;
    check("par_perr_wack", 16'(bus_if.o_perr), 16'h1);
    check("par_ack_wack", 16'(bus_if.o_ack), 16'h1);
    tick();
    check("par_perr_idle", 16'(bus_if.o_perr), 16'h0);
    bus_if.i_par  = 1'b0;
    bus_if.i_req  = 1'b1;
    bus_if.i_we   = 1'b1;
    bus_if.i_addr = 2'd2;
    tb_dat        = 10'h003;
    tick();
    bus_if.i_req = 1'b0;
    tb_dat       = 10'h000;
    check("par_ok_no_perr", 16'(bus_if.o_perr), 16'h0);
    tick();
    bus_if.i_req  = 1'b1;
    bus_if.i_we   = 1'b0;
    bus_if.i_addr = 2'd0;
    tick();
    bus_if.i_req = 1'b0;
    check("par_turn_par", 16'(bus_if.o_par), 16'h0);
    tb_oe = 1'b0;
    tick();
    check("par_drive_par", 16'(bus_if.o_par), 16'h1);
    check("par_drive_bus", 16'(bus_if.io_bus), 16'h001);
    tick();
    tb_oe = 1'b1;
    check("par_rel_par", 16'(bus_if.o_par), 16'h0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
